// File: rtl/count_check_pkg.sv
// rtl/count_check_pkg.sv - shared types and defaults for the packet count checker
package count_check_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned STALL_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ready_throttle.sv
// rtl/ready_throttle.sv - registered stream ready with a post-accept stall window
// run is the next-state view of RUN so ready lines up with the FSM register.
module ready_throttle
  import count_check_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               accept,
  input  logic [STALL_W-1:0] stall_cycles,
  output logic               ready
);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               ready_q, ready_d;

  always_comb begin
    stall_d = stall_q;
    if (!run) begin
      stall_d = '0;
    end else if (accept) begin
      stall_d = stall_cycles;
    end else if (stall_q != '0) begin
      stall_d = stall_q - STALL_W'(1);
    end
    // ready returns on the cycle after the window counts down to zero
    ready_d = run && (stall_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      ready_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/count_check.sv
// rtl/count_check.sv - checks an incrementing 1..count_up_to packet stream
// and keeps saturating beat, packet and error statistics.
module count_check
  import count_check_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH_DEF,
  parameter int unsigned CntWidth  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [31:0]          count_up_to,
  input  logic [CntWidth-1:0]  num_pkts,
  input  logic [STALL_W-1:0]   stall_cycles,
  output logic                 readReq,
  input  logic [DataWidth-1:0] readData,
  input  logic                 readDataValid,
  output logic                 readDataReady,
  input  logic                 readDataLast,
  output logic [CntWidth-1:0]  pkt_count,
  output logic [CntWidth-1:0]  beat_count,
  output logic [CntWidth-1:0]  err_count,
  output logic                 error,
  output logic [DataWidth-1:0] err_data,
  output logic                 done
);

  state_e               state_q, state_d;
  logic                 ready;
  logic                 accept;
  logic [DataWidth-1:0] target;
  logic                 mismatch, early_last, missing_last, beat_err;

  logic [DataWidth-1:0] expected_q, expected_d;
  logic [CntWidth-1:0]  pkt_q, pkt_d;
  logic [CntWidth-1:0]  beat_q, beat_d;
  logic [CntWidth-1:0]  errc_q, errc_d;
  logic                 error_q, error_d;
  logic [DataWidth-1:0] err_data_q, err_data_d;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  assign accept = readDataValid && ready;
  assign target = DataWidth'(count_up_to);

  assign mismatch     = readData != expected_q;
  assign early_last   = readDataLast && (readData != target);
  assign missing_last = !readDataLast && (readData == target);
  assign beat_err     = mismatch || early_last || missing_last;

  always_comb begin
    expected_d = expected_q;
    pkt_d      = pkt_q;
    beat_d     = beat_q;
    errc_d     = errc_q;
    error_d    = error_q;
    err_data_d = err_data_q;
    if (accept) begin
      beat_d = sat_inc(beat_q);
      // readData+1 both continues a clean run and resyncs after a mismatch
      expected_d = readDataLast ? DataWidth'(1) : readData + DataWidth'(1);
      if (readDataLast) begin
        pkt_d = sat_inc(pkt_q);
      end
      if (beat_err) begin
        errc_d     = sat_inc(errc_q);
        error_d    = 1'b1;
        err_data_d = readData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if ((num_pkts != '0) && (pkt_d >= num_pkts)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  ready_throttle u_ready_throttle (
    .clk          (clk),
    .reset        (reset),
    .run          (state_d == ST_RUN),
    .accept       (accept),
    .stall_cycles (stall_cycles),
    .ready        (ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      expected_q <= DataWidth'(1);
      pkt_q      <= '0;
      beat_q     <= '0;
      errc_q     <= '0;
      error_q    <= 1'b0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      pkt_q      <= pkt_d;
      beat_q     <= beat_d;
      errc_q     <= errc_d;
      error_q    <= error_d;
      err_data_q <= err_data_d;
    end
  end

  assign readReq       = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign readDataReady = ready;
  assign pkt_count     = pkt_q;
  assign beat_count    = beat_q;
  assign err_count     = errc_q;
  assign error         = error_q;
  assign err_data      = err_data_q;

endmodule
